// File: rtl/mem_stream_reader.sv
// mem_stream_reader: consumer end of the memory-block priority-encoder path.
// Decodes the registered binary block select into a one-hot read strobe, walks
// the chosen block's entries, pulses blk_done so the encoder advances, and
// merges all words of an event into one valid/ready output stream.
// Optional feature macro: MEM_READER_TAG_EN (adds a 4-bit block tag above dout).
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  1-cycle pulse beginning an event
//   sel, none              binary select (1..NBLK) and 'no block' flag from encoder
//   nent                   packed per-block entry counts, block i at [i*AW +: AW]
//   rd_en, rd_addr         one-hot read strobe and shared read address
//   rd_data                muxed read data, RD_LAT cycles after rd_en
//   blk_done               one-hot pulse: selected block fully read
//   dout, dout_valid/ready merged output stream
//   busy, evt_done         event in progress / event finished pulse
module mem_stream_reader #(
  parameter int unsigned NBLK    = 12,
  parameter int unsigned DW      = 36,
  parameter int unsigned AW      = 6,
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned SEL_LAT = 2,
`ifdef MEM_READER_TAG_EN
  localparam int unsigned OW     = DW + 4
`else
  localparam int unsigned OW     = DW
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         sel,
  input  logic               none,
  input  logic [NBLK*AW-1:0] nent,
  output logic [NBLK-1:0]    rd_en,
  output logic [AW-1:0]      rd_addr,
  input  logic [DW-1:0]      rd_data,
  output logic [NBLK-1:0]    blk_done,
  output logic [OW-1:0]      dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               busy,
  output logic               evt_done
);

  localparam int unsigned DEPTH = RD_LAT + 2;
  localparam int unsigned FCW   = $clog2(DEPTH + 1);
  localparam int unsigned SW    = FCW + 1;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned WCW   = $clog2(SEL_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_FLUSH} state_t;

  state_t            r_state, w_state_nx;
  logic [WCW-1:0]    r_wcnt, w_wcnt_nx;
  logic [3:0]        r_blk, w_blk_nx;
  logic [AW-1:0]     r_icnt, w_icnt_nx;
  logic [NBLK-1:0]   r_rd_en, w_rd_en_nx;
  logic [AW-1:0]     r_rd_addr, w_rd_addr_nx;
  logic [NBLK-1:0]   r_blk_done, w_blk_done_nx;
  logic              r_busy, w_busy_nx;
  logic              r_evt_done, w_evt_done_nx;

  logic [RD_LAT-1:0] r_lat;
  logic [OW-1:0]     r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [FCW-1:0]    r_fcnt;
  logic [OW-1:0]     r_dout;
  logic              r_dout_valid;

  logic              w_sel_ok, w_push, w_load, w_room, w_drained;
  logic [3:0]        w_sel_idx;
  int unsigned       w_sel_base;
  logic [AW-1:0]     w_sel_nent, w_cur_nent;
  logic [NBLK-1:0]   w_sel_oh, w_cur_oh;
  logic [SW-1:0]     w_fcnt_nx, w_pend;
  logic [OW-1:0]     w_push_word;

  assign rd_en      = r_rd_en;
  assign rd_addr    = r_rd_addr;
  assign blk_done   = r_blk_done;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = r_busy;
  assign evt_done   = r_evt_done;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  // Select decode; invalid codes read entry count of block 0 (unused then)
  assign w_sel_ok   = !none && (sel != 4'd0) && (32'(sel) <= NBLK);
  assign w_sel_idx  = sel - 4'd1;
  assign w_sel_base = w_sel_ok ? 32'(w_sel_idx) * AW : 0;
  assign w_sel_nent = nent[w_sel_base +: AW];
  assign w_sel_oh   = NBLK'(1) << w_sel_idx;
  assign w_cur_nent = nent[32'(r_blk) * AW +: AW];
  assign w_cur_oh   = NBLK'(1) << r_blk;

  // Word arriving from memory this cycle, and FIFO head move into dout
  assign w_push    = r_lat[RD_LAT-1];
  assign w_load    = (r_fcnt != '0) && (!r_dout_valid || dout_ready);
  assign w_fcnt_nx = SW'(r_fcnt) + SW'(w_push) - SW'(w_load);

  // Strobes still to land in the FIFO, excluding the one writing now
  always_comb begin
    w_pend = SW'(|r_rd_en);
    for (int i = 0; i < int'(RD_LAT) - 1; i++) w_pend = w_pend + SW'(r_lat[i]);
  end

  assign w_room    = (w_fcnt_nx + w_pend) < SW'(DEPTH);
  assign w_drained = (r_fcnt == '0) && (r_lat == '0) && (r_rd_en == '0) && !r_dout_valid;

  // Next-state and registered-output logic
  always_comb begin
    w_state_nx     = r_state;
    w_wcnt_nx      = r_wcnt;
    w_blk_nx       = r_blk;
    w_icnt_nx      = r_icnt;
    w_rd_en_nx     = '0;
    w_rd_addr_nx   = r_rd_addr;
    w_blk_done_nx  = '0;
    w_busy_nx      = r_busy;
    w_evt_done_nx  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_WAIT;
          w_wcnt_nx  = '0;
          w_busy_nx  = 1'b1;
        end
      end
      S_WAIT: begin
        if (r_wcnt == WCW'(SEL_LAT)) begin
          if (!w_sel_ok) begin
            if (w_drained) begin
              w_state_nx    = S_IDLE;
              w_busy_nx     = 1'b0;
              w_evt_done_nx = 1'b1;
            end else begin
              w_state_nx = S_FLUSH;
            end
          end else if (w_sel_nent == '0) begin
            w_blk_done_nx = w_sel_oh;
            w_wcnt_nx     = '0;
          end else begin
            // First strobe goes out on the select-sample cycle to save a cycle per block
            w_blk_nx     = w_sel_idx;
            w_state_nx   = S_READ;
            w_rd_addr_nx = '0;
            w_icnt_nx    = '0;
            if (w_room) begin
              w_rd_en_nx = w_sel_oh;
              w_icnt_nx  = AW'(1);
            end
          end
        end else begin
          w_wcnt_nx = r_wcnt + WCW'(1);
        end
      end
      S_READ: begin
        if (r_icnt == w_cur_nent) begin
          w_blk_done_nx = w_cur_oh;
          w_state_nx    = S_WAIT;
          w_wcnt_nx     = '0;
        end else if (w_room) begin
          w_rd_en_nx   = w_cur_oh;
          w_rd_addr_nx = r_icnt;
          w_icnt_nx    = r_icnt + AW'(1);
        end
      end
      S_FLUSH: begin
        if (w_drained) begin
          w_state_nx    = S_IDLE;
          w_busy_nx     = 1'b0;
          w_evt_done_nx = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // FSM and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wcnt     <= '0;
      r_blk      <= '0;
      r_icnt     <= '0;
      r_rd_en    <= '0;
      r_rd_addr  <= '0;
      r_blk_done <= '0;
      r_busy     <= 1'b0;
      r_evt_done <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_wcnt     <= w_wcnt_nx;
      r_blk      <= w_blk_nx;
      r_icnt     <= w_icnt_nx;
      r_rd_en    <= w_rd_en_nx;
      r_rd_addr  <= w_rd_addr_nx;
      r_blk_done <= w_blk_done_nx;
      r_busy     <= w_busy_nx;
      r_evt_done <= w_evt_done_nx;
    end
  end

`ifdef MEM_READER_TAG_EN
  // Block index travels with each strobe through the read latency
  logic [3:0] r_tag [RD_LAT];
  always_ff @(posedge clk) begin
    r_tag[0] <= r_blk;
    for (int i = 1; i < int'(RD_LAT); i++) r_tag[i] <= r_tag[i-1];
  end
  assign w_push_word = {r_tag[RD_LAT-1], rd_data};
`else
  assign w_push_word = rd_data;
`endif

  // Read-latency tracker, skid FIFO pointers and output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fcnt       <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_lat  <= {r_lat[RD_LAT-2:0], |r_rd_en};
      r_fcnt <= FCW'(w_fcnt_nx);
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_load) begin
        r_rd_ptr     <= ptr_inc(r_rd_ptr);
        r_dout       <= r_mem[r_rd_ptr];
        r_dout_valid <= 1'b1;
      end else if (dout_ready) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_word;
  end

endmodule
